// File: rtl/cnff_cell.sv
// cnff_cell: 1-bit change/no-change flip-flop.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears q to 0
//   c     - change value: with n=1, 1 toggles q and 0 forces q to 0
//   n     - change request: 0 holds q
//   q     - stored bit
module cnff_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic c,
   input  logic n,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else if (n) begin
         q <= c ? ~q : 1'b0;
      end
   end

endmodule

// File: rtl/cnff_counter.sv
// cnff_counter: synchronous modulo-MOD up/down counter whose state lives
// in a bank of change/no-change cells, one cell per count bit.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count=0, wrap=0)
//   en    - count enable, one step per edge
//   up    - direction, 1 = increment, 0 = decrement (used only when en=1)
//   clr   - synchronous clear to 0, has priority over en
//   count - current count, taken straight from the cell outputs
//   tc    - combinational terminal count for the current request
//   wrap  - registered pulse, high with the wrapped count value
module cnff_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   generate
      if (WIDTH < 1 || WIDTH > 31 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
         $error("cnff_counter: MOD must lie in 2..2**WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] n;
   logic             term_up;
   logic             term_dn;

   always_comb begin
      term_up = (count == MAX);
      term_dn = (count == '0);
      tc      = en & ~clr & (up ? term_up : term_dn);

      nxt = count;
      if (clr) begin
         nxt = '0;
      end else if (en) begin
         if (up) begin
            nxt = term_up ? '0 : count + 1'b1;
         end else begin
            nxt = term_dn ? MAX : count - 1'b1;
         end
      end

      // A cell only sees a request when its bit changes: 0->1 toggles,
      // 1->0 forces zero, so c is simply the target bit.
      c = nxt;
      n = (nxt ^ count) | (~nxt & count);
   end

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_cell
         cnff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .c     (c[i]),
            .n     (n[i]),
            .q     (count[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
      end else begin
         wrap <= tc;
      end
   end

endmodule

// File: tb/tb_cnff_counter.sv
module tb_cnff_counter;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         up;
   logic         clr;
   logic [W-1:0] count;
   logic         tc;
   logic         wrap;

   int checks = 0;
   int errors = 0;

   // reference state: count as a plain integer in 0..MOD-1, wrap as a flag
   int m  = 0;
   bit mw = 1'b0;

   cnff_counter #(.WIDTH(W), .MOD(MOD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .up    (up),
      .clr   (clr),
      .count (count),
      .tc    (tc),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_tc(input bit e, input bit u, input bit c);
      if (c || !e) return 1'b0;
      return u ? (m == MOD - 1) : (m == 0);
   endfunction

   function automatic void model_edge(input bit e, input bit u, input bit c);
      mw = model_tc(e, u, c);
      if (c)      m = 0;
      else if (e) m = u ? (m + 1) % MOD : (m + MOD - 1) % MOD;
   endfunction

   // one clock step: drive at the falling edge, check tc there,
   // then check count/wrap just after the rising edge
   task automatic step(input bit e, input bit u, input bit c);
      @(negedge clk);
      en = e; up = u; clr = c;
      #1;
      chk("tc", 32'(tc), 32'(model_tc(e, u, c)));
      @(posedge clk);
      model_edge(e, u, c);
      #1;
      chk("count", 32'(count), 32'(m));
      chk("wrap", 32'(wrap), 32'(mw));
   endtask

   task automatic async_reset();
      @(negedge clk);
      en = 1'b0; up = 1'b1; clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m = 0; mw = 1'b0;
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_wrap", 32'(wrap), 32'(0));
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;
      #2;
      chk("reset_count", 32'(count), 32'(0));
      chk("reset_wrap", 32'(wrap), 32'(0));
      chk("reset_tc_idle", 32'(tc), 32'(0));
      en = 1'b1; up = 1'b0;
      #1;
      chk("reset_tc_down", 32'(tc), 32'(1));
      en = 1'b0; up = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // 12 increments: through 9, wrap to 0, on to 2
      for (int i = 0; i < 12; i++) step(1, 1, 0);
      chk("up12_count", 32'(count), 32'(2));

      // down from 0: wraps to 9, then 8, 7
      while (m != 0) step(1, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      chk("down_count", 32'(count), 32'(7));

      // clear at 5 with en/up set
      while (m != 5) step(1, 1, 0);
      step(1, 1, 1);
      // clear at 9 suppresses the wrap
      while (m != 9) step(1, 1, 0);
      step(1, 1, 1);
      chk("clr_at_9_wrap", 32'(wrap), 32'(0));

      // hold at 6 while up toggles
      while (m != 6) step(1, 1, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);

      // asynchronous reset mid-cycle at 7, first increment goes to 1
      while (m != 7) step(1, 1, 0);
      async_reset();
      step(1, 1, 0);
      chk("post_reset_count", 32'(count), 32'(1));

      // direction flip at 9: two wraps one cycle apart
      while (m != 9) step(1, 1, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      chk("flip_wrap", 32'(wrap), 32'(1));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         step($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 19) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
